mem_arb_ctrl: RTL and testbench

Parametrised memory subsystem for the CPU board. It replaces the two independent instruction and data RAMs, and their bidirectional buses, with one single-ported storage array. An instruction-fetch port and a data port share that array through an arbiter with configurable wait states and a req/ack handshake. It sits between the CPU's `i_addr_bus`/`d_addr_bus` sides and the storage array.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_array.sv | 23 ++
 rtl/mem_arb_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_arb_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the arbitrated memory subsystem.
// FSM states, port selector and the anti-starvation limit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

  localparam int STARVE_LIMIT = 2;

endpackage

// File: rtl/mem_array.sv
// mem_array: synchronous single-port RAM, registered read.
// Contents are never reset.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // read-before-write: rdata shows the word as it was before this edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: I-fetch and data ports sharing one single-port array.
// Define MEM_ARB_CTRL_BOUNDS_EN to suppress and flag out-of-range accesses.
module mem_arb_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err
);

  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] LIM = 2'(STARVE_LIMIT);

  state_t            state, state_nx;
  port_t             gnt, port_q;
  logic [ADDR_W-1:0] addr_q, sel_addr, ram_addr_full;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q, ram_rdata, rd_val;
  logic [2:0]        cnt_q;
  logic [1:0]        streak_q;
  logic              start, access, oor, ram_we;
  logic              unused_addr;

  assign start  = (state == IDLE) && (i_req || d_req);
  assign access = (state == BUSY) && (cnt_q == 3'd0);

  // D wins unless I has been passed over STARVE_LIMIT times in a row
  always_comb begin
    gnt = PORT_I;
    if (d_req && !(i_req && streak_q >= LIM)) gnt = PORT_D;
  end

  assign sel_addr = (gnt == PORT_D) ? d_addr : i_addr;

  // address one cycle early so the registered read lands in the access cycle
  assign ram_addr_full = (state == IDLE) ? sel_addr : addr_q;
  assign unused_addr   = ^ram_addr_full;

`ifdef MEM_ARB_CTRL_BOUNDS_EN
  assign oor = 32'(addr_q) >= 32'(DEPTH);
`else
  assign oor = 1'b0;
`endif

  assign ram_we = access && we_q && !oor;
  assign rd_val = oor ? '0 : ram_rdata;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr_full[MW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY:    if (cnt_q == 3'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // grant latch, wait counter, streak and registered responses
  always_ff @(posedge clk) begin
    if (reset) begin
      port_q   <= PORT_I;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      streak_q <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      err      <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      if (start) begin
        port_q  <= gnt;
        addr_q  <= sel_addr;
        we_q    <= (gnt == PORT_D) && d_we;
        wdata_q <= d_wdata;
        cnt_q   <= 3'(WAIT_STATES);
        if (gnt == PORT_I)
          streak_q <= '0;
        else if (i_req && streak_q < LIM)
          streak_q <= streak_q + 2'd1;
      end
      if (state == BUSY && cnt_q != 3'd0)
        cnt_q <= cnt_q - 3'd1;
      if (access) begin
        err <= oor;
        if (port_q == PORT_D) begin
          d_ack   <= 1'b1;
          d_rdata <= rd_val;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= rd_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb_mem_arb_ctrl: scoreboard bench, dut0 WAIT_STATES=0, dut1 WAIT_STATES=3.
// Honours MEM_ARB_CTRL_BOUNDS_EN when computing out-of-range expectations.
module tb_mem_arb_ctrl;

  typedef struct {
    logic        d;
    logic [15:0] data;
    logic        dc;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       rst, i_req, d_req, d_we;
  logic [1:0][15:0] i_addr, d_addr, d_wdata;
  wire  [1:0]       i_ack, d_ack, err;
  wire  [1:0][15:0] i_rdata, d_rdata;

  exp_t q[2][$];
  int   checks = 0;
  int   errors = 0;
  int   s;
  logic pd;

  mem_arb_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .reset(rst[0]),
    .i_req(i_req[0]), .i_addr(i_addr[0]),
    .i_rdata(i_rdata[0]), .i_ack(i_ack[0]),
    .d_req(d_req[0]), .d_we(d_we[0]),
    .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
    .err(err[0])
  );

  mem_arb_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(3)
  ) dut1 (
    .clk(clk), .reset(rst[1]),
    .i_req(i_req[1]), .i_addr(i_addr[1]),
    .i_rdata(i_rdata[1]), .i_ack(i_ack[1]),
    .d_req(d_req[1]), .d_we(d_we[1]),
    .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
    .err(err[1])
  );

  task automatic check(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic mon(int u);
    exp_t e;
    if (i_ack[u] || d_ack[u]) begin
      if (q[u].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d spurious ack @%0d: got ack, expected none",
                 u, cyc);
      end else begin
        e = q[u].pop_front();
        check($sformatf("dut%0d port", u), 32'(d_ack[u]), 32'(e.d));
        check($sformatf("dut%0d ack cycle", u), 32'(cyc), 32'(e.cyc));
        check($sformatf("dut%0d err", u), 32'(err[u]), 32'(e.err));
        if (!e.dc)
          check($sformatf("dut%0d rdata", u),
                32'(e.d ? d_rdata[u] : i_rdata[u]), 32'(e.data));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic op(int u, logic d, logic we, logic [15:0] a,
                    logic [15:0] wd, logic [15:0] ed, logic dc,
                    logic ee, logic mut);
    bit got = 1'b0;
    if (d) begin
      d_req[u] = 1'b1; d_we[u] = we;
      d_addr[u] = a;   d_wdata[u] = wd;
    end else begin
      i_req[u] = 1'b1; i_addr[u] = a;
    end
    q[u].push_back('{d, ed, dc, ee, cyc + 2 + (u == 0 ? 0 : 3)});
    if (mut) begin
      @(posedge clk); #1;
      d_addr[u]  = d_addr[u] ^ 16'h0030;
      d_wdata[u] = ~d_wdata[u];
      d_we[u]    = ~d_we[u];
    end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = d ? d_ack[u] : i_ack[u];
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL dut%0d ack timeout: got none, expected ack", u);
    end
    @(posedge clk); #1;
    if (d) d_req[u] = 1'b0;
    else   i_req[u] = 1'b0;
  endtask

  initial begin
    rst = 2'b11; i_req = '0; d_req = '0; d_we = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;
    for (int u = 0; u < 2; u++) begin
      check("reset i_ack", 32'(i_ack[u]), 32'h0);
      check("reset d_ack", 32'(d_ack[u]), 32'h0);
      check("reset err", 32'(err[u]), 32'h0);
      check("reset i_rdata", 32'(i_rdata[u]), 32'h0);
      check("reset d_rdata", 32'(d_rdata[u]), 32'h0);
    end

    op(0, 1, 1, 16'h0010, 16'hBEEF, 16'h0, 1, 0, 0);
    op(0, 0, 0, 16'h0010, 16'h0, 16'hBEEF, 0, 0, 0);
    op(0, 1, 1, 16'h0010, 16'hCAFE, 16'hBEEF, 0, 0, 0);
    op(0, 0, 0, 16'h0010, 16'h0, 16'hCAFE, 0, 0, 0);
    op(0, 1, 1, 16'h0000, 16'h1111, 16'h0, 1, 0, 0);
    op(0, 1, 0, 16'h0000, 16'h0, 16'h1111, 0, 0, 0);

    s = cyc;
    i_req[0] = 1'b1; i_addr[0] = 16'h0000;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0010;
    for (int k = 0; k < 6; k++) begin
      pd = (k % 3 != 2);
      q[0].push_back('{pd, pd ? 16'hCAFE : 16'h1111,
                       1'b0, 1'b0, s + 2 + 3 * k});
    end
    repeat (18) @(posedge clk);
    #1;
    i_req[0] = 1'b0; d_req[0] = 1'b0;

    op(0, 1, 1, 16'h0FFF, 16'h7777, 16'h0, 1, 0, 0);
    op(0, 0, 0, 16'h0FFF, 16'h0, 16'h7777, 0, 0, 0);
`ifdef MEM_ARB_CTRL_BOUNDS_EN
    op(0, 1, 0, 16'h1000, 16'h0, 16'h0000, 0, 1, 0);
    op(0, 1, 1, 16'h1010, 16'h9999, 16'h0000, 0, 1, 0);
    op(0, 0, 0, 16'h0010, 16'h0, 16'hCAFE, 0, 0, 0);
`else
    op(0, 1, 0, 16'h1000, 16'h0, 16'h1111, 0, 0, 0);
    op(0, 1, 1, 16'h1010, 16'h9999, 16'hCAFE, 0, 0, 0);
    op(0, 0, 0, 16'h0010, 16'h0, 16'h9999, 0, 0, 0);
`endif

    op(1, 1, 1, 16'h0020, 16'h0ABC, 16'h0, 1, 0, 0);
    op(1, 1, 0, 16'h0020, 16'h0, 16'h0ABC, 0, 0, 0);

    d_req[1] = 1'b1; d_we[1] = 1'b1;
    d_addr[1] = 16'h0020; d_wdata[1] = 16'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1'b1; d_req[1] = 1'b0; d_we[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    check("mid reset d_rdata", 32'(d_rdata[1]), 32'h0);
    check("mid reset d_ack", 32'(d_ack[1]), 32'h0);
    repeat (6) @(posedge clk);
    #1;
    op(1, 1, 0, 16'h0020, 16'h0, 16'h0ABC, 0, 0, 0);

    op(1, 1, 0, 16'h0020, 16'h0, 16'h0ABC, 0, 0, 1);
    op(1, 1, 1, 16'h0050, 16'h0077, 16'h0, 1, 0, 1);
    op(1, 1, 0, 16'h0050, 16'h0, 16'h0077, 0, 0, 0);
    op(1, 0, 0, 16'h0050, 16'h0, 16'h0077, 0, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++)
      check($sformatf("dut%0d leftover expects", u),
            32'(q[u].size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
